mult_control: RTL and testbench
===============================

Name: mult_control

Overview:
- Control FSM for the 8x8 sequential multiplier. Built from one 4x4 partial-product multiplier, a shifter/adder, and the 16-bit accumulator register.
- Drives the accumulator's clock-enable and active-low sync-clear inputs, which this block is the other end of. Also drives the nibble-select and shift-select muxes, plus status and done outputs.
- A product takes one clear cycle and four accumulate cycles.

Parameters:
- None. The step count (4), select widths (2) and state width (3) are fixed by the 8x8/4x4 datapath and defined in mult_pkg.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- sclr  input  1  synchronous active-high reset, highest priority
- start  input  1  single-cycle request to begin a multiply
- input_sel  output  2  bit0 = A nibble (0 lo, 1 hi); bit1 = B nibble (0 lo, 1 hi)
- shift_sel  output  2  00 = <<0, 01 = <<4, 10 = <<8, 11 unused (never driven)
- acc_ena  output  1  to the accumulator clk_ena
- acc_sclr_n  output  1  to the accumulator sclr_n; active-low clear, effective only with acc_ena=1
- busy  output  1  high in CLR and STEP
- done  output  1  one-cycle pulse; accumulator holds the final product this cycle
- err  output  1  high in ERR
- state_out  output  3  current state encoding, for the 7-segment debug display

Interface (already decided):
- One clock, clk.
- Reset sclr is synchronous and active-high.

Behaviour:
- Moore machine. All outputs decode only from the state register and the 2-bit step counter; there is no combinational path from start.
- States and encodings: IDLE=0, CLR=1, STEP=2, DONE=3, ERR=4. Encodings 5-7 are illegal and recover to IDLE on the next edge.
- sclr=1 at any edge, including mid-operation: state=IDLE, count=0. Outputs then read acc_ena=0, acc_sclr_n=1, input_sel=00, shift_sel=00, busy=0, done=0, err=0, state_out=0.
- IDLE: if start=1 go to CLR, else stay.
- CLR: acc_ena=1, acc_sclr_n=0, so the accumulator clears at the next edge.
  - start=1 here (start held longer than one cycle) goes to ERR.
  - Otherwise go to STEP with count=0.
- STEP: acc_ena=1, acc_sclr_n=1, and the step counter increments each cycle. Per count:
  - count 0: input_sel=00, shift_sel=00
  - count 1: input_sel=01, shift_sel=01
  - count 2: input_sel=10, shift_sel=01
  - count 3: input_sel=11, shift_sel=10
- STEP exits:
  - After count 3, go to DONE and wrap count to 0.
  - start=1 during any STEP cycle goes to ERR. The accumulate for that cycle still completes, since outputs are Moore; ERR drives acc_ena=0 thereafter.
- DONE: done=1, acc_ena=0.
  - start=1 goes to CLR (back-to-back operation, no IDLE cycle).
  - Otherwise go to IDLE.
- ERR: err=1, acc_ena=0, count held at 0.
  - Stay while start=1.
  - Go to IDLE when start=0.
- Latency: start sampled at edge T gives CLR in cycle T+1, STEP in T+2..T+5, and DONE in T+6.
- The product is valid on the accumulator output from T+6 until the next CLR edge. The accumulator is not cleared on return to IDLE.
- Counter rules: the counter is 2 bits and wraps 3 to 0 only on the STEP-to-DONE transition. It is forced to 0 in every state other than STEP.

Decomposition:
- mult_pkg holds:
  - state encodings: ST_IDLE, ST_CLR, ST_STEP, ST_DONE, ST_ERR
  - shift codes: SH_0, SH_4, SH_8
  - NUM_STEPS=4
  - select-width constants
- Sub-module mult_step_counter: 2-bit counter with inputs clk, sclr, clr, inc, output count. The FSM drives clr for every state other than STEP and inc in STEP.

Test Plan:
- Reset: sclr=1 for 2 cycles mid-STEP (count=2) -> next cycle state_out=0, acc_ena=0, acc_sclr_n=1, busy=0, count=0.
- Nominal: 1-cycle start at T -> state_out=1 at T+1 with acc_sclr_n=0; input_sel/shift_sel = 00/00, 01/01, 10/01, 11/10 across T+2..T+5; done=1 only at T+6; state_out=0 at T+7.
- System check with the 4x4 multiplier, shifter/adder and accumulator: A=8'hFF, B=8'hFF -> accumulator 16'hFE01 when done=1. A=8'h12, B=8'h34 -> 16'h03A8.
- Back-to-back: start=1 during the DONE cycle -> CLR the next cycle, done low; the second product (8'h0F*8'h10=16'h00F0) is correct, with no stale accumulation.
- Error: start pulsed again in STEP count=1 -> err=1 next cycle, acc_ena=0; start held high 3 cycles -> err stays 1; start low -> IDLE the following cycle.
- Held start: start high for 2 cycles from IDLE -> CLR then ERR, and the STEP state is never entered.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared types and constants for the 8x8 sequential multiplier control.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int NUM_STEPS = 4;
    localparam int SEL_W     = 2;
    localparam int STATE_W   = 3;
    localparam int CNT_W     = $clog2(NUM_STEPS);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_STEP = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [SEL_W-1:0] SH_0 = 2'b00;
    localparam logic [SEL_W-1:0] SH_4 = 2'b01;
    localparam logic [SEL_W-1:0] SH_8 = 2'b10;

    // Cross terms (lo*hi, hi*lo) share the <<4 weight; only hi*hi needs <<8.
    function automatic logic [SEL_W-1:0] shift_for_step(input logic [CNT_W-1:0] cnt);
        logic [SEL_W-1:0] sh;
        case (cnt)
            2'd0:    sh = SH_0;
            2'd1:    sh = SH_4;
            2'd2:    sh = SH_4;
            default: sh = SH_8;
        endcase
        return sh;
    endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : mult_step_counter
// Purpose  : 2-bit accumulate-step counter; clr has priority over inc.
// Revision : 1.0 - initial release
// ============================================================================
module mult_step_counter
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             sclr,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : mult_step_counter
`default_nettype wire

// File: rtl/mult_control.sv
`default_nettype none
// ============================================================================
// Module   : mult_control
// Purpose  : Moore control FSM sequencing the 4x4 partial products into the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module mult_control
    import mult_pkg::*;
(
    input  logic               clk,
    input  logic               sclr,
    input  logic               start,
    output logic [SEL_W-1:0]   input_sel,
    output logic [SEL_W-1:0]   shift_sel,
    output logic               acc_ena,
    output logic               acc_sclr_n,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [STATE_W-1:0] state_out
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count;
    logic             last_step;
    logic             cnt_clr;
    logic             cnt_inc;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_step = (count == CNT_W'(NUM_STEPS - 1));

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = start ? ST_CLR : ST_IDLE;
            ST_CLR:  state_d = start ? ST_ERR : ST_STEP;
            ST_STEP: begin
                if (start) begin
                    state_d = ST_ERR;
                end else if (last_step) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_DONE: state_d = start ? ST_CLR : ST_IDLE;
            ST_ERR:  state_d = start ? ST_ERR : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Clearing on the STEP exit edge keeps the count at zero in every non-STEP cycle,
    // including the first ERR cycle after an aborted step.
    assign cnt_inc = (state_q == ST_STEP);
    assign cnt_clr = !cnt_inc || (state_d != ST_STEP);

    mult_step_counter u_step_counter (
        .clk   (clk),
        .sclr  (sclr),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count)
    );

    always_comb begin
        acc_ena    = 1'b0;
        acc_sclr_n = 1'b1;
        input_sel  = '0;
        shift_sel  = SH_0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            ST_CLR: begin
                acc_ena    = 1'b1;
                acc_sclr_n = 1'b0;
                busy       = 1'b1;
            end
            ST_STEP: begin
                acc_ena   = 1'b1;
                busy      = 1'b1;
                input_sel = count;
                shift_sel = shift_for_step(count);
            end
            ST_DONE: done = 1'b1;
            ST_ERR:  err  = 1'b1;
            default: ;
        endcase
    end

    assign state_out = state_q;

endmodule : mult_control
`default_nettype wire

// File: tb/tb_mult_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_control
// Purpose  : Self-checking bench: cycle vector table plus multiplier system scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_control;

    logic       clk = 1'b0;
    logic       sclr;
    logic       start;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;
    logic       acc_ena;
    logic       acc_sclr_n;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] state_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mult_control dut (
        .clk        (clk),
        .sclr       (sclr),
        .start      (start),
        .input_sel  (input_sel),
        .shift_sel  (shift_sel),
        .acc_ena    (acc_ena),
        .acc_sclr_n (acc_sclr_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .state_out  (state_out)
    );

    // Reference datapath: 4x4 multiplier, shifter/adder and accumulator
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  pp;
    logic [15:0] addend;
    logic [15:0] acc;

    always_comb begin
        nib_a  = input_sel[0] ? op_a[7:4] : op_a[3:0];
        nib_b  = input_sel[1] ? op_b[7:4] : op_b[3:0];
        pp     = {4'b0, nib_a} * {4'b0, nib_b};
        addend = {8'b0, pp} << {shift_sel, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (acc_ena) begin
            acc <= acc_sclr_n ? (acc + addend) : 16'h0000;
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
        end
    endtask

    // Scoreboard: expected product pushed at start, popped on done
    logic [15:0] sb_q[$];
    logic        sb_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (sb_en && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 16'h0001, 16'h0000);
            end else begin
                check("product", acc, sb_q.pop_front());
            end
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, 16'(sb_q.size()), 16'd0);
    endtask

    task automatic run_product(input logic [7:0] a, input logic [7:0] b, input string name);
        op_a = a;
        op_b = b;
        sb_q.push_back(16'(a) * 16'(b));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain(name);
    endtask

    // Packed outputs: {state_out, acc_ena, acc_sclr_n, input_sel, shift_sel, busy, done, err}
    localparam logic [11:0] O_IDLE = {3'd0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [11:0] O_CLR  = {3'd1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    localparam logic [11:0] O_S0   = {3'd2, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    localparam logic [11:0] O_S1   = {3'd2, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    localparam logic [11:0] O_S2   = {3'd2, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0};
    localparam logic [11:0] O_S3   = {3'd2, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0};
    localparam logic [11:0] O_DONE = {3'd3, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    localparam logic [11:0] O_ERR  = {3'd4, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};

    typedef struct {
        logic        sclr;
        logic        start;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic st, input logic [11:0] e);
        vec_t v;
        v.sclr  = s;
        v.start = st;
        v.exp   = e;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] got;
        int          n;
        sclr  = 1'b1;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;

        // reset
        add(1, 0, O_IDLE); add(1, 0, O_IDLE);
        // nominal single product
        add(0, 1, O_CLR);  add(0, 0, O_S0); add(0, 0, O_S1); add(0, 0, O_S2);
        add(0, 0, O_S3);   add(0, 0, O_DONE); add(0, 0, O_IDLE); add(0, 0, O_IDLE);
        // back-to-back: start during DONE restarts without an IDLE cycle
        add(0, 1, O_CLR);  add(0, 0, O_S0); add(0, 0, O_S1); add(0, 0, O_S2);
        add(0, 0, O_S3);   add(0, 0, O_DONE);
        add(0, 1, O_CLR);  add(0, 0, O_S0); add(0, 0, O_S1); add(0, 0, O_S2);
        add(0, 0, O_S3);   add(0, 0, O_DONE); add(0, 0, O_IDLE);
        // start re-asserted at STEP count 1 and held 3 cycles
        add(0, 1, O_CLR);  add(0, 0, O_S0); add(0, 0, O_S1);
        add(0, 1, O_ERR);  add(0, 1, O_ERR); add(0, 1, O_ERR); add(0, 0, O_IDLE);
        // start held 2 cycles from IDLE: CLR then ERR, never STEP
        add(0, 1, O_CLR);  add(0, 1, O_ERR); add(0, 0, O_IDLE);
        // sclr mid-STEP at count 2, then restart proves count was cleared
        add(0, 1, O_CLR);  add(0, 0, O_S0); add(0, 0, O_S1); add(0, 0, O_S2);
        add(1, 0, O_IDLE); add(1, 0, O_IDLE);
        add(0, 1, O_CLR);  add(0, 0, O_S0); add(0, 0, O_S1); add(0, 0, O_S2);
        add(0, 0, O_S3);   add(0, 0, O_DONE); add(0, 0, O_IDLE);

        for (int i = 0; i < tbl.size(); i++) begin
            sclr  = tbl[i].sclr;
            start = tbl[i].start;
            @(posedge clk);
            #1;
            got = {state_out, acc_ena, acc_sclr_n, input_sel, shift_sel, busy, done, err};
            check($sformatf("row%0d", i), {4'b0, got}, {4'b0, tbl[i].exp});
        end
        sclr  = 1'b0;
        start = 1'b0;

        // System products through the reference datapath
        sb_en = 1'b1;
        run_product(8'hFF, 8'hFF, "drain_ff_ff");
        run_product(8'h12, 8'h34, "drain_12_34");
        run_product(8'hA7, 8'h5C, "drain_a7_5c");

        // Back-to-back product: the second result must not carry the first
        op_a = 8'hFF;
        op_b = 8'hFF;
        sb_q.push_back(16'hFE01);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (state_out != 3'd3 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_reach_done", {13'b0, state_out}, 16'd3);
        op_a = 8'h0F;
        op_b = 8'h10;
        sb_q.push_back(16'h00F0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_clr_state", {12'b0, state_out, done}, {12'b0, 3'd1, 1'b0});
        wait_drain("drain_b2b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mult_control
`default_nettype wire
